// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbitrating N:1 multiplexer.
package arb_pkg;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Channel index width; a single-channel mux still carries a 1-bit select.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational arbiter: fixed priority (lowest index) or round-robin from ptr.
module rr_grant
    import arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]           req,
    input  logic [sel_w(N)-1:0]    ptr,
    input  arb_mode_e              rr_mode,
    output logic [N-1:0]           gnt,
    output logic [sel_w(N)-1:0]    gnt_idx,
    output logic                   any_gnt
);

    localparam int unsigned SEL_W = sel_w(N);

    // First pass covers [ptr, N-1] (whole range in fixed mode); second pass wraps to [0, ptr).
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!any_gnt && req[i] && ((rr_mode == ARB_FIXED) || (i >= int'(ptr)))) begin
                gnt[i]  = 1'b1;
                gnt_idx = SEL_W'(i);
                any_gnt = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!any_gnt && req[i]) begin
                gnt[i]  = 1'b1;
                gnt_idx = SEL_W'(i);
                any_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux_nx1.sv
// N-input arbitrating multiplexer with valid/ready handshakes and a registered output beat.
module arb_mux_nx1
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N       = 4,
    parameter bit          RR_MODE = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [N-1:0]           i_in_valid,
    input  logic [N*WIDTH-1:0]     i_in_data,
    output logic [N-1:0]           o_in_ready,
    output logic                   o_out_valid,
    output logic [WIDTH-1:0]       o_out_data,
    output logic [sel_w(N)-1:0]    o_out_sel,
    input  logic                   i_out_ready
);

    localparam int unsigned SEL_W = sel_w(N);
    localparam arb_mode_e   MODE  = RR_MODE ? ARB_RR : ARB_FIXED;

    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_sel;
    logic [SEL_W-1:0]    r_ptr;

    logic                w_load_en;
    logic [N-1:0]        w_gnt;
    logic [SEL_W-1:0]    w_gnt_idx;
    logic                w_any_gnt;
    logic [WIDTH-1:0]    w_sel_data;

    // Output register is empty or being drained this cycle.
    assign w_load_en = !r_out_valid || i_out_ready;

    rr_grant #(
        .N (N)
    ) u_rr_grant (
        .req     (i_in_valid),
        .ptr     (r_ptr),
        .rr_mode (MODE),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any_gnt (w_any_gnt)
    );

    // Accept only the granted channel, and only when the output can take a beat.
    assign o_in_ready = (w_load_en && !i_reset) ? w_gnt : '0;

    // One-hot OR mux of the granted channel's payload.
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt[i]) begin
                w_sel_data = w_sel_data | i_in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output beat register and round-robin pointer.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_load_en) begin
            if (w_any_gnt) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_sel   <= w_gnt_idx;
                if (RR_MODE) begin
                    r_ptr <= (w_gnt_idx == SEL_W'(N - 1)) ? '0 : w_gnt_idx + SEL_W'(1);
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux_nx1.sv
// Directed bench for arb_mux_nx1: RR N=4, fixed N=4, RR N=3 and N=1 instances.
module tb_arb_mux_nx1;

    logic clk;
    logic rst;

    int checks;
    int errors;

    // RR, N=4
    logic [3:0]    a_valid;
    logic [127:0]  a_data;
    logic [3:0]    a_ready;
    logic          a_ovalid;
    logic [31:0]   a_odata;
    logic [1:0]    a_osel;
    logic          a_oready;

    // Fixed, N=4
    logic [3:0]    f_valid;
    logic [127:0]  f_data;
    logic [3:0]    f_ready;
    logic          f_ovalid;
    logic [31:0]   f_odata;
    logic [1:0]    f_osel;
    logic          f_oready;

    // RR, N=3
    logic [2:0]    t_valid;
    logic [95:0]   t_data;
    logic [2:0]    t_ready;
    logic          t_ovalid;
    logic [31:0]   t_odata;
    logic [1:0]    t_osel;
    logic          t_oready;

    // N=1
    logic          s_valid;
    logic [31:0]   s_data;
    logic          s_ready;
    logic          s_ovalid;
    logic [31:0]   s_odata;
    logic          s_osel;
    logic          s_oready;

    arb_mux_nx1 #(.WIDTH(32), .N(4), .RR_MODE(1'b1)) u_rr4 (
        .i_clk(clk), .i_reset(rst), .i_in_valid(a_valid), .i_in_data(a_data),
        .o_in_ready(a_ready), .o_out_valid(a_ovalid), .o_out_data(a_odata),
        .o_out_sel(a_osel), .i_out_ready(a_oready));

    arb_mux_nx1 #(.WIDTH(32), .N(4), .RR_MODE(1'b0)) u_fx4 (
        .i_clk(clk), .i_reset(rst), .i_in_valid(f_valid), .i_in_data(f_data),
        .o_in_ready(f_ready), .o_out_valid(f_ovalid), .o_out_data(f_odata),
        .o_out_sel(f_osel), .i_out_ready(f_oready));

    arb_mux_nx1 #(.WIDTH(32), .N(3), .RR_MODE(1'b1)) u_rr3 (
        .i_clk(clk), .i_reset(rst), .i_in_valid(t_valid), .i_in_data(t_data),
        .o_in_ready(t_ready), .o_out_valid(t_ovalid), .o_out_data(t_odata),
        .o_out_sel(t_osel), .i_out_ready(t_oready));

    arb_mux_nx1 #(.WIDTH(32), .N(1), .RR_MODE(1'b1)) u_n1 (
        .i_clk(clk), .i_reset(rst), .i_in_valid(s_valid), .i_in_data(s_data),
        .o_in_ready(s_ready), .o_out_valid(s_ovalid), .o_out_data(s_odata),
        .o_out_sel(s_osel), .i_out_ready(s_oready));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] rr_seq [8];
        logic [1:0] rr3_seq [3];
        rr_seq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
        rr3_seq = '{2'd2, 2'd0, 2'd1};
        checks = 0;
        errors = 0;
        rst = 1'b1;
        a_valid = '0; a_data = '0; a_oready = 1'b0;
        f_valid = '0; f_data = '0; f_oready = 1'b0;
        t_valid = '0; t_data = '0; t_oready = 1'b0;
        s_valid = '0; s_data = '0; s_oready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_a_valid", 64'(a_ovalid), 64'd0);
        chk("rst_a_data",  64'(a_odata),  64'd0);
        chk("rst_a_sel",   64'(a_osel),   64'd0);
        chk("rst_f_valid", 64'(f_ovalid), 64'd0);
        chk("rst_t_valid", 64'(t_ovalid), 64'd0);
        chk("rst_s_valid", 64'(s_ovalid), 64'd0);
        rst = 1'b0;

        // RR N=4 fairness: all channels valid, continuous drain
        for (int i = 0; i < 4; i++) a_data[i*32 +: 32] = 32'hA0 + 32'(i);
        a_valid = 4'b1111;
        a_oready = 1'b1;
        #1;
        chk("rr4_ready0", 64'(a_ready), 64'b0001);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rr4_valid", 64'(a_ovalid), 64'd1);
            chk("rr4_sel",   64'(a_osel),   64'(rr_seq[k]));
            chk("rr4_data",  64'(a_odata),  64'h0A0 + 64'(rr_seq[k]));
            chk("rr4_ready", 64'(a_ready),  64'(4'b0001 << ((k + 1) % 4)));
        end
        a_valid = 4'b0000;
        #1;
        chk("rr4_noreq_ready", 64'(a_ready), 64'd0);
        tick();
        chk("rr4_drain_valid", 64'(a_ovalid), 64'd0);
        chk("rr4_drain_data",  64'(a_odata),  64'hA3);
        chk("rr4_drain_sel",   64'(a_osel),   64'd3);

        // Backpressure: hold DEADBEEF from channel 2 for five stalled cycles
        a_oready = 1'b0;
        a_valid = 4'b0100;
        a_data[2*32 +: 32] = 32'hDEADBEEF;
        #1;
        chk("bp_load_ready", 64'(a_ready), 64'b0100);
        tick();
        a_valid = 4'b1000;
        a_data[3*32 +: 32] = 32'h12345678;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_ready", 64'(a_ready),  64'd0);
            chk("bp_data",  64'(a_odata),  64'hDEADBEEF);
            chk("bp_sel",   64'(a_osel),   64'd2);
            chk("bp_valid", 64'(a_ovalid), 64'd1);
            tick();
        end
        a_oready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(a_ready), 64'b1000);
        tick();
        chk("bp_refill_data",  64'(a_odata),  64'h12345678);
        chk("bp_refill_sel",   64'(a_osel),   64'd3);
        chk("bp_refill_valid", 64'(a_ovalid), 64'd1);
        a_valid = 4'b0000;
        tick();
        chk("bp_empty", 64'(a_ovalid), 64'd0);

        // Reset asserted mid-stall discards the held beat; arbitration restarts at 0
        a_oready = 1'b0;
        a_valid = 4'b0010;
        a_data[1*32 +: 32] = 32'h55;
        tick();
        chk("rs_held_sel",  64'(a_osel),  64'd1);
        chk("rs_held_data", 64'(a_odata), 64'h55);
        #2;
        rst = 1'b1;
        #1;
        chk("rs_valid", 64'(a_ovalid), 64'd0);
        chk("rs_data",  64'(a_odata),  64'd0);
        chk("rs_sel",   64'(a_osel),   64'd0);
        chk("rs_ready", 64'(a_ready),  64'd0);
        a_valid = 4'b1111;
        a_oready = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        chk("rs_first_ready", 64'(a_ready), 64'b0001);
        tick();
        chk("rs_first_sel", 64'(a_osel), 64'd0);
        a_valid = 4'b0000;
        a_oready = 1'b0;

        // Fixed priority N=4: channel 1 beats channel 3 until it drops
        f_data[1*32 +: 32] = 32'h11;
        f_data[3*32 +: 32] = 32'h33;
        f_valid = 4'b1010;
        f_oready = 1'b1;
        #1;
        chk("fx_ready1", 64'(f_ready), 64'b0010);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fx_sel1",  64'(f_osel),  64'd1);
            chk("fx_data1", 64'(f_odata), 64'h11);
        end
        f_valid = 4'b1000;
        #1;
        chk("fx_ready3", 64'(f_ready), 64'b1000);
        tick();
        chk("fx_sel3",  64'(f_osel),  64'd3);
        chk("fx_data3", 64'(f_odata), 64'h33);
        f_valid = 4'b1111;
        tick();
        chk("fx_all_sel_a", 64'(f_osel), 64'd0);
        tick();
        chk("fx_all_sel_b", 64'(f_osel), 64'd0);
        f_valid = 4'b0000;

        // RR N=3: move PTR to 2, then a request set without channel 2 wraps to 0
        for (int i = 0; i < 3; i++) t_data[i*32 +: 32] = 32'hC0 + 32'(i);
        t_oready = 1'b1;
        t_valid = 3'b010;
        tick();
        chk("rr3_setup_sel", 64'(t_osel), 64'd1);
        t_valid = 3'b011;
        #1;
        chk("rr3_wrap_ready", 64'(t_ready), 64'b001);
        tick();
        chk("rr3_wrap_sel", 64'(t_osel), 64'd0);
        t_valid = 3'b111;
        #1;
        chk("rr3_ptr1_ready", 64'(t_ready), 64'b010);
        tick();
        chk("rr3_ptr1_sel", 64'(t_osel), 64'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rr3_seq_sel",  64'(t_osel),  64'(rr3_seq[k]));
            chk("rr3_seq_data", 64'(t_odata), 64'hC0 + 64'(rr3_seq[k]));
        end
        t_valid = 3'b000;

        // N=1: pipeline register with alternating backpressure
        s_oready = 1'b1;
        s_valid = 1'b1;
        s_data = 32'h100;
        #1;
        chk("n1_ready_a", 64'(s_ready), 64'd1);
        tick();
        chk("n1_valid_a", 64'(s_ovalid), 64'd1);
        chk("n1_data_a",  64'(s_odata),  64'h100);
        chk("n1_sel_a",   64'(s_osel),   64'd0);
        s_data = 32'h101;
        s_oready = 1'b0;
        #1;
        chk("n1_stall_ready", 64'(s_ready), 64'd0);
        tick();
        chk("n1_stall_data", 64'(s_odata), 64'h100);
        s_oready = 1'b1;
        #1;
        chk("n1_refill_ready", 64'(s_ready), 64'd1);
        tick();
        chk("n1_refill_data", 64'(s_odata), 64'h101);
        s_data = 32'h102;
        s_oready = 1'b0;
        tick();
        chk("n1_hold_data",  64'(s_odata),  64'h101);
        chk("n1_hold_valid", 64'(s_ovalid), 64'd1);
        s_oready = 1'b1;
        tick();
        chk("n1_next_data", 64'(s_odata), 64'h102);
        s_valid = 1'b0;
        tick();
        chk("n1_drain_valid", 64'(s_ovalid), 64'd0);
        chk("n1_drain_data",  64'(s_odata),  64'h102);
        s_oready = 1'b0;
        s_valid = 1'b1;
        s_data = 32'h103;
        #1;
        chk("n1_empty_ready", 64'(s_ready), 64'd1);
        tick();
        chk("n1_last_data",  64'(s_odata),  64'h103);
        chk("n1_last_valid", 64'(s_ovalid), 64'd1);
        chk("n1_last_sel",   64'(s_osel),   64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
